// File: rtl/prach_fft2_bf_stage.sv
// -----------------------------------------------------------------------------
// prach_fft2_bf_stage
//
// Single-path delay-feedback radix-2 butterfly stage for the PRACH FFT.
// Sample n of a frame occupies NUM_CHANNELS consecutive valid beats. During
// the first half of a frame the inputs are parked in a (L/2)*C delay line.
// During the second half each input b meets its partner a = x[n-L/2]: the sum
// a+b is output at once and the difference a-b is pushed back into the delay
// line. The differences are emitted during the next frame's first half.
//
// Parameters
//   WIDTH          signed sample width of I and Q
//   NUM_FFT_LENGTH butterfly span L (power of two, >= 2)
//   NUM_CHANNELS   time-interleaved channel count C (>= 1)
//
// Ports
//   clk                rising-edge clock
//   rst                asynchronous active-high reset
//   din_dr / din_di    signed input sample (I / Q)
//   din_dv             input beat valid
//   sync_in            first beat of a frame (n=0, ch=0), qualified by din_dv
//   scale_in           1 = divide-by-2 for this frame, sampled with sync_in
//   ovf_clr            clears the sticky overflow flag
//   dout_dr / dout_di  signed output sample (registered)
//   dout_dv            output beat valid (registered)
//   sync_out           first sum beat of an output frame (registered)
//   ovf                sticky saturation flag (registered)
// -----------------------------------------------------------------------------
module prach_fft2_bf_stage #(
    parameter int WIDTH          = 18,
    parameter int NUM_FFT_LENGTH = 8,
    parameter int NUM_CHANNELS   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] din_dr,
    input  logic signed [WIDTH-1:0] din_di,
    input  logic                    din_dv,
    input  logic                    sync_in,
    input  logic                    scale_in,
    input  logic                    ovf_clr,
    output logic signed [WIDTH-1:0] dout_dr,
    output logic signed [WIDTH-1:0] dout_di,
    output logic                    dout_dv,
    output logic                    sync_out,
    output logic                    ovf
);

    localparam int HALF  = NUM_FFT_LENGTH / 2;
    localparam int DEPTH = HALF * NUM_CHANNELS;
    localparam int NW    = $clog2(NUM_FFT_LENGTH);
    localparam int CW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    // Result of one rounded/saturated butterfly output component.
    typedef struct packed {
        logic [WIDTH-1:0] val;
        logic             sat;
    } res_t;

    // (WIDTH+1)-bit intermediate -> WIDTH-bit result.
    // scale=1: (s+1)>>>1, round half up; cannot overflow.
    // scale=0: clamp to the signed WIDTH-bit range and flag saturation.
    function automatic res_t scale_sat(input logic signed [WIDTH:0] s,
                                       input logic scale);
        res_t                  r;
        logic signed [WIDTH:0] rnd;
        rnd   = s + (WIDTH+1)'(1);
        r.sat = 1'b0;
        r.val = s[WIDTH-1:0];
        if (scale) begin
            r.val = rnd[WIDTH:1];
        end else if (s[WIDTH] != s[WIDTH-1]) begin
            r.sat = 1'b1;
            r.val = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
        end
        return r;
    endfunction

    // Frame position and control state
    logic [NW-1:0] n_cnt;
    logic [CW-1:0] ch_cnt;
    logic          primed;
    logic          scale_reg;

    // Delay line: I in the upper half, Q in the lower half of each entry.
    logic [2*WIDTH-1:0] dly [DEPTH];

    // Combinational view of the current beat
    logic                    beat_sync;
    logic [NW-1:0]           n_cur;
    logic [CW-1:0]           ch_cur;
    logic                    second_half;
    logic                    last_n;
    logic                    last_ch;
    logic                    resync;
    logic                    primed_eff;
    logic                    cur_scale;
    logic signed [WIDTH-1:0] a_r;
    logic signed [WIDTH-1:0] a_i;
    res_t                    sum_r, sum_i, dif_r, dif_i;
    logic [2*WIDTH-1:0]      push;
    logic                    any_sat;

    // NOTE: every signal driven here gets a default first so no path through
    // the block can leave it unassigned and infer a latch.
    always_comb begin
        beat_sync   = din_dv && sync_in;
        // A valid sync beat is n=0, ch=0 regardless of where the counters are.
        n_cur       = beat_sync ? '0 : n_cnt;
        ch_cur      = beat_sync ? '0 : ch_cnt;
        // L is a power of two, so n >= L/2 is just the counter MSB.
        second_half = n_cur[NW-1];
        last_n      = (n_cur == NW'(NUM_FFT_LENGTH - 1));
        last_ch     = (ch_cur == CW'(NUM_CHANNELS - 1));
        // Sync landing mid-frame: whatever sits in the delay line is stale.
        resync      = beat_sync && (n_cnt != '0);
        primed_eff  = primed && !resync;
        cur_scale   = beat_sync ? scale_in : scale_reg;

        a_r = dly[DEPTH-1][2*WIDTH-1:WIDTH];
        a_i = dly[DEPTH-1][WIDTH-1:0];

        sum_r = scale_sat((WIDTH+1)'(a_r) + (WIDTH+1)'(din_dr), cur_scale);
        sum_i = scale_sat((WIDTH+1)'(a_i) + (WIDTH+1)'(din_di), cur_scale);
        dif_r = scale_sat((WIDTH+1)'(a_r) - (WIDTH+1)'(din_dr), cur_scale);
        dif_i = scale_sat((WIDTH+1)'(a_i) - (WIDTH+1)'(din_di), cur_scale);

        // Differences are stored already scaled with the producing frame's
        // scale, so a later frame's scale setting cannot touch them.
        push    = second_half ? {dif_r.val, dif_i.val} : {din_dr, din_di};
        any_sat = sum_r.sat | sum_i.sat | dif_r.sat | dif_i.sat;
    end

    // NOTE: the delay line is plain storage whose contents are don't-care
    // after reset; leaving it off the reset keeps it a simple shift memory.
    always_ff @(posedge clk) begin
        if (din_dv) begin
            dly[0] <= push;
            for (int i = 1; i < DEPTH; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_cnt     <= '0;
            ch_cnt    <= '0;
            primed    <= 1'b0;
            scale_reg <= 1'b0;
            dout_dr   <= '0;
            dout_di   <= '0;
            dout_dv   <= 1'b0;
            sync_out  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (din_dv) begin
                if (last_ch) begin
                    ch_cnt <= '0;
                    n_cnt  <= last_n ? '0 : n_cur + 1'b1;
                end else begin
                    ch_cnt <= ch_cur + 1'b1;
                    n_cnt  <= n_cur;
                end
                if (beat_sync) begin
                    scale_reg <= scale_in;
                end
                if (resync) begin
                    primed <= 1'b0;
                end else if (second_half && last_n && last_ch) begin
                    primed <= 1'b1;
                end
            end

            dout_dv  <= din_dv && (second_half || primed_eff);
            sync_out <= din_dv && second_half &&
                        (n_cur == NW'(HALF)) && (ch_cur == '0);

            // Data holds its last value on beats that produce no output.
            if (din_dv && second_half) begin
                dout_dr <= sum_r.val;
                dout_di <= sum_i.val;
            end else if (din_dv && primed_eff) begin
                dout_dr <= a_r;
                dout_di <= a_i;
            end

            // A new saturation wins over a simultaneous clear.
            if (din_dv && second_half && any_sat) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prach_fft2_bf_stage.sv
// -----------------------------------------------------------------------------
// tb_prach_fft2_bf_stage
//
// Scoreboard bench for prach_fft2_bf_stage. Two instances: A (L=4, C=1) and
// B (L=4, C=2). Stimulus tasks push the hand-computed expected output for
// each beat into a per-instance queue; a monitor per instance pops and
// compares whenever dout_dv is seen on the falling edge.
// -----------------------------------------------------------------------------
module tb_prach_fft2_bf_stage;

    localparam int W = 18;

    typedef struct {
        int dr;
        int di;
        bit sync;
    } exp_t;

    logic clk;
    logic rst;

    // Instance A signals
    logic signed [W-1:0] a_din_dr, a_din_di, a_dout_dr, a_dout_di;
    logic a_din_dv, a_sync_in, a_scale_in, a_ovf_clr;
    logic a_dout_dv, a_sync_out, a_ovf;

    // Instance B signals
    logic signed [W-1:0] b_din_dr, b_din_di, b_dout_dr, b_dout_di;
    logic b_din_dv, b_sync_in, b_scale_in, b_ovf_clr;
    logic b_dout_dv, b_sync_out, b_ovf;

    exp_t q_a[$];
    exp_t q_b[$];
    int   tests = 0;
    int   fails = 0;
    int   gap_a = 0;

    prach_fft2_bf_stage #(.WIDTH(W), .NUM_FFT_LENGTH(4), .NUM_CHANNELS(1)) dut_a (
        .clk(clk), .rst(rst),
        .din_dr(a_din_dr), .din_di(a_din_di), .din_dv(a_din_dv),
        .sync_in(a_sync_in), .scale_in(a_scale_in), .ovf_clr(a_ovf_clr),
        .dout_dr(a_dout_dr), .dout_di(a_dout_di), .dout_dv(a_dout_dv),
        .sync_out(a_sync_out), .ovf(a_ovf)
    );

    prach_fft2_bf_stage #(.WIDTH(W), .NUM_FFT_LENGTH(4), .NUM_CHANNELS(2)) dut_b (
        .clk(clk), .rst(rst),
        .din_dr(b_din_dr), .din_di(b_din_di), .din_dv(b_din_dv),
        .sync_in(b_sync_in), .scale_in(b_scale_in), .ovf_clr(b_ovf_clr),
        .dout_dr(b_dout_dr), .dout_di(b_dout_di), .dout_dv(b_dout_dv),
        .sync_out(b_sync_out), .ovf(b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor A
    always @(negedge clk) begin
        if (a_dout_dv === 1'b1) begin
            if (q_a.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL a_unexpected_dv: got dout_dv=1, expected 0 (t=%0t)", $time);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_dout_dr", int'(a_dout_dr), e.dr);
                check("a_dout_di", int'(a_dout_di), e.di);
                check("a_sync_out", int'(a_sync_out), int'(e.sync));
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (b_dout_dv === 1'b1) begin
            if (q_b.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL b_unexpected_dv: got dout_dv=1, expected 0 (t=%0t)", $time);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_dout_dr", int'(b_dout_dr), e.dr);
                check("b_dout_di", int'(b_dout_di), e.di);
                check("b_sync_out", int'(b_sync_out), int'(e.sync));
            end
        end
    end

    // One valid beat into A, followed by gap_a idle cycles. Called and
    // returns at posedge+1. ev=1 means this beat must produce (edr, edi, esync).
    task automatic send_a(input int dr, input int di, input bit sync, input bit scl,
                          input bit ev, input int edr, input int edi, input bit esync);
        if (ev) q_a.push_back('{edr, edi, esync});
        a_din_dr   = W'(dr);
        a_din_di   = W'(di);
        a_din_dv   = 1'b1;
        a_sync_in  = sync;
        a_scale_in = scl;
        @(posedge clk);
        #1;
        a_din_dv   = 1'b0;
        a_sync_in  = 1'b0;
        a_scale_in = 1'b0;
        repeat (gap_a) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_b(input int dr, input int di, input bit sync,
                          input bit ev, input int edr, input int edi, input bit esync);
        if (ev) q_b.push_back('{edr, edi, esync});
        b_din_dr  = W'(dr);
        b_din_di  = W'(di);
        b_din_dv  = 1'b1;
        b_sync_in = sync;
        @(posedge clk);
        #1;
        b_din_dv  = 1'b0;
        b_sync_in = 1'b0;
    endtask

    // Frame [1,2,3,4]/[10..40] then [5..8]/[50..80] into A, with the diffs
    // from the previous frame expected during the first one if primed.
    task automatic frames_1234_5678(input bit primed_in, input int pd0r, input int pd0i,
                                    input int pd1r, input int pd1i);
        send_a(1, 10, 1, 0, primed_in, pd0r, pd0i, 0);
        send_a(2, 20, 0, 0, primed_in, pd1r, pd1i, 0);
        send_a(3, 30, 0, 0, 1, 4, 40, 1);
        send_a(4, 40, 0, 0, 1, 6, 60, 0);
        send_a(5, 50, 1, 0, 1, -2, -20, 0);
        send_a(6, 60, 0, 0, 1, -2, -20, 0);
        send_a(7, 70, 0, 0, 1, 12, 120, 1);
        send_a(8, 80, 0, 0, 1, 14, 140, 0);
    endtask

    initial begin
        int drain;
        rst = 1'b1;
        a_din_dr = '0; a_din_di = '0; a_din_dv = 1'b0;
        a_sync_in = 1'b0; a_scale_in = 1'b0; a_ovf_clr = 1'b0;
        b_din_dr = '0; b_din_di = '0; b_din_dv = 1'b0;
        b_sync_in = 1'b0; b_scale_in = 1'b0; b_ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_dout_dr", int'(a_dout_dr), 0);
        check("rst_dout_di", int'(a_dout_di), 0);
        check("rst_dout_dv", int'(a_dout_dv), 0);
        check("rst_sync_out", int'(a_sync_out), 0);
        check("rst_ovf", int'(a_ovf), 0);

        // Continuous frames, unprimed start
        frames_1234_5678(0, 0, 0, 0, 0);

        // Same frames with 3 idle cycles between beats
        gap_a = 3;
        frames_1234_5678(1, -2, -20, -2, -20);
        gap_a = 0;

        // Scaling frame [3,0,1,0] / [-3,5,0,2], scale=1
        send_a(3, -3, 1, 1, 1, -2, -20, 0);
        send_a(0, 5, 0, 0, 1, -2, -20, 0);
        send_a(1, 0, 0, 0, 1, 2, -1, 1);
        send_a(0, 2, 0, 0, 1, 0, 4, 0);
        check("scale_ovf", int'(a_ovf), 0);

        // Saturation frame, scale=0; the diffs emitted first still carry the
        // scaled values of the previous frame.
        send_a(131071, 0, 1, 0, 1, 1, -1, 0);
        send_a(-131072, 0, 0, 0, 1, 0, 2, 0);
        send_a(1, 0, 0, 0, 1, 131071, 0, 1);
        check("sat_sum_ovf", int'(a_ovf), 1);
        a_ovf_clr = 1'b1;
        send_a(1, 0, 0, 0, 1, -131071, 0, 0);
        check("ovf_set_beats_clr", int'(a_ovf), 1);
        @(posedge clk);
        #1;
        a_ovf_clr = 1'b0;
        check("ovf_clr", int'(a_ovf), 0);

        // Resync at n=2 (stored diffs 131070 and -131072 come out first)
        send_a(1, 0, 1, 0, 1, 131070, 0, 0);
        send_a(2, 0, 0, 0, 1, -131072, 0, 0);
        send_a(3, 0, 0, 0, 1, 4, 0, 1);
        send_a(10, 0, 1, 0, 0, 0, 0, 0);
        send_a(20, 0, 0, 0, 0, 0, 0, 0);
        send_a(30, 0, 0, 0, 1, 40, 0, 1);
        send_a(40, 0, 0, 0, 1, 60, 0, 0);

        // Reset mid-frame
        send_a(1, 0, 1, 0, 1, -20, 0, 0);
        send_a(2, 0, 0, 0, 1, -20, 0, 0);
        send_a(3, 0, 0, 0, 1, 4, 0, 1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_dout_dr", int'(a_dout_dr), 0);
        check("midrst_dout_di", int'(a_dout_di), 0);
        check("midrst_dout_dv", int'(a_dout_dv), 0);
        check("midrst_sync_out", int'(a_sync_out), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First post-reset frame emits no diffs
        frames_1234_5678(0, 0, 0, 0, 0);
        send_a(1, 10, 1, 0, 1, -2, -20, 0);
        send_a(2, 20, 0, 0, 1, -2, -20, 0);
        send_a(3, 30, 0, 0, 1, 4, 40, 1);
        send_a(4, 40, 0, 0, 1, 6, 60, 0);

        // Instance B: two interleaved channels, ch0=[1,2,3,4] ch1=[10..40]
        for (int f = 0; f < 2; f++) begin
            send_b(1, -1, 1, f == 1, -2, 2, 0);
            send_b(10, -10, 0, f == 1, -20, 20, 0);
            send_b(2, -2, 0, f == 1, -2, 2, 0);
            send_b(20, -20, 0, f == 1, -20, 20, 0);
            send_b(3, -3, 0, 1, 4, -4, 1);
            send_b(30, -30, 0, 1, 40, -40, 0);
            send_b(4, -4, 0, 1, 6, -6, 0);
            send_b(40, -40, 0, 1, 60, -60, 0);
        end
        check("b_ovf", int'(b_ovf), 0);

        // Let the monitors consume the last outputs, bounded.
        drain = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && drain < 20) begin
            @(negedge clk);
            drain++;
        end
        @(negedge clk);
        while (q_a.size() != 0) begin
            exp_t e;
            e = q_a.pop_front();
            tests++;
            fails++;
            $display("FAIL a_missing_output: got none, expected dr=%0d di=%0d", e.dr, e.di);
        end
        while (q_b.size() != 0) begin
            exp_t e;
            e = q_b.pop_front();
            tests++;
            fails++;
            $display("FAIL b_missing_output: got none, expected dr=%0d di=%0d", e.dr, e.di);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
